// File: rtl/click_event_merge.sv
// Player-input front end: per-channel synchroniser, debouncer and edge detector, merged into one
// serialised event stream with holdoff rate limiting, pending/overrun tracking and an event counter.
module click_event_merge #(
  parameter  int N_CH            = 2,
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 65000,
  parameter  int HOLDOFF_CYCLES  = 0,
  parameter  int CNT_W           = 8,
  localparam int CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  raw_in,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic [N_CH-1:0]  edge_sel,
  input  logic             clr_stats,
  output logic [N_CH-1:0]  ch_level,
  output logic             event_pulse,
  output logic [CH_W-1:0]  event_ch,
  output logic [CNT_W-1:0] event_count,
  output logic [N_CH-1:0]  overrun
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [N_CH-1:0]  sync_out;
  logic [N_CH-1:0]  level_w;
  logic [N_CH-1:0]  prev_reg;
  logic [N_CH-1:0]  edge_w;
  logic [N_CH-1:0]  pending_reg, pending_next;
  logic [N_CH-1:0]  pend_req;
  logic [N_CH-1:0]  grant_vec;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_en;
  logic [N_CH-1:0]  overrun_reg, overrun_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             pulse_reg;
  logic [CH_W-1:0]  ch_reg, ch_next;
  logic [HO_W-1:0]  hold_cnt_reg, hold_cnt_next;
  state_t           state_reg, state_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign sync_out[gi] = sync_reg[SYNC_STAGES-1];

      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        // The last synchroniser flop already gives a registered level.
        assign level_w[gi] = sync_out[gi];
      end else begin : g_debounce
        logic [DB_W-1:0] db_cnt_reg;
        logic            level_reg;

        always_ff @(posedge clk) begin
          if (!rst) begin
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
          end else if (sync_out[gi] == level_reg) begin
            db_cnt_reg <= '0;
          end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt_reg <= '0;
            level_reg  <= ~level_reg;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end

        assign level_w[gi] = level_reg;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= level_w;
    end
  end

  assign edge_w   = ((level_w & ~prev_reg & ~edge_sel) | (~level_w & prev_reg & edge_sel)) & ch_enable;
  // A pending bit whose channel was just disabled must not be granted.
  assign pend_req = pending_reg & ch_enable;

  always_comb begin
    grant_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_req[i]) begin
        grant_idx = CH_W'(i);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // FSM next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if ((|pend_req) && (HOLDOFF_CYCLES > 0)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_reg == HO_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    grant_en      = 1'b0;
    grant_vec     = '0;
    hold_cnt_next = hold_cnt_reg;
    ch_next       = ch_reg;
    case (state_reg)
      IDLE: begin
        if (|pend_req) begin
          grant_en             = 1'b1;
          grant_vec[grant_idx] = 1'b1;
          ch_next              = grant_idx;
          hold_cnt_next        = HO_W'(HOLDOFF_CYCLES);
        end
      end
      HOLD: begin
        hold_cnt_next = hold_cnt_reg - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_next = (edge_w | (pending_reg & ~grant_vec)) & ch_enable;
    overrun_next = (clr_stats ? '0 : overrun_reg) | (edge_w & pending_reg & ~grant_vec);
    count_next   = clr_stats ? '0 : count_reg;
    if (grant_en && (count_next != {CNT_W{1'b1}})) begin
      count_next = count_next + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= '0;
      overrun_reg <= '0;
      count_reg   <= '0;
      pulse_reg   <= 1'b0;
      ch_reg      <= '0;
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      count_reg   <= count_next;
      pulse_reg   <= grant_en;
      ch_reg      <= ch_next;
    end
  end

  assign ch_level    = level_w;
  assign event_pulse = pulse_reg;
  assign event_ch    = ch_reg;
  assign event_count = count_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_click_event_merge.sv
// Scoreboard bench for click_event_merge: four instances cover latency, debounce, holdoff,
// overrun/clear, edge select, channel enable, counter saturation and reset during holdoff.
module tb_click_event_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    int ch;
    int cnt;
  } exp_t;

  exp_t q_a[$], q_b[$], q_c[$], q_d[$];

  // A: no debounce, no holdoff. B: debounce 10. C: holdoff 3. D: holdoff 20, 2-bit counter.
  logic       rst_a, rst_b, rst_c, rst_d;
  logic [1:0] raw_a, raw_b, raw_c, raw_d;
  logic [1:0] en_a, en_b, en_c, en_d;
  logic [1:0] sel_a, sel_b, sel_c, sel_d;
  logic       clr_a, clr_b, clr_c, clr_d;
  logic [1:0] lvl_a, lvl_b, lvl_c, lvl_d;
  logic       pulse_a, pulse_b, pulse_c, pulse_d;
  logic       ch_a, ch_b, ch_c, ch_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  logic [1:0] ovr_a, ovr_b, ovr_c, ovr_d;

  click_event_merge #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .HOLDOFF_CYCLES(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst_a), .raw_in(raw_a), .ch_enable(en_a), .edge_sel(sel_a), .clr_stats(clr_a),
    .ch_level(lvl_a), .event_pulse(pulse_a), .event_ch(ch_a), .event_count(cnt_a), .overrun(ovr_a));

  click_event_merge #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(10), .HOLDOFF_CYCLES(0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst_b), .raw_in(raw_b), .ch_enable(en_b), .edge_sel(sel_b), .clr_stats(clr_b),
    .ch_level(lvl_b), .event_pulse(pulse_b), .event_ch(ch_b), .event_count(cnt_b), .overrun(ovr_b));

  click_event_merge #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .HOLDOFF_CYCLES(3), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst_c), .raw_in(raw_c), .ch_enable(en_c), .edge_sel(sel_c), .clr_stats(clr_c),
    .ch_level(lvl_c), .event_pulse(pulse_c), .event_ch(ch_c), .event_count(cnt_c), .overrun(ovr_c));

  click_event_merge #(.N_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .HOLDOFF_CYCLES(20), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst_d), .raw_in(raw_d), .ch_enable(en_d), .edge_sel(sel_d), .clr_stats(clr_d),
    .ch_level(lvl_d), .event_pulse(pulse_d), .event_ch(ch_d), .event_count(cnt_d), .overrun(ovr_d));

  task automatic check(input string tag, input int got, input int expv);
    checks_total++;
    if (got == expv) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expv);
  endtask

  task automatic take(input int which, input string name, input int ch, input int cnt);
    exp_t e;
    int   sz;
    case (which)
      0: sz = q_a.size();
      1: sz = q_b.size();
      2: sz = q_c.size();
      default: sz = q_d.size();
    endcase
    $display("inst %s event ch=%0d count=%0d at cycle %0d", name, ch, cnt, cyc);
    if (sz == 0) begin
      check({name, "_unexpected_event"}, 1, 0);
    end else begin
      case (which)
        0: e = q_a.pop_front();
        1: e = q_b.pop_front();
        2: e = q_c.pop_front();
        default: e = q_d.pop_front();
      endcase
      check({name, "_event_ch"}, ch, e.ch);
      check({name, "_event_count"}, cnt, e.cnt);
    end
  endtask

  int a_pcyc = 0, b_pcyc = 0, d_pcyc = 0;
  int c_pcyc[4];
  int c_n = 0;

  always @(posedge clk) begin
    #1;
    if (pulse_a) begin a_pcyc = cyc; take(0, "a", int'(ch_a), int'(cnt_a)); end
    if (pulse_b) begin b_pcyc = cyc; take(1, "b", int'(ch_b), int'(cnt_b)); end
    if (pulse_c) begin
      if (c_n < 4) c_pcyc[c_n] = cyc;
      c_n++;
      take(2, "c", int'(ch_c), int'(cnt_c));
    end
    if (pulse_d) begin d_pcyc = cyc; take(3, "d", int'(ch_d), int'(cnt_d)); end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0;
  int d_model;

  initial begin
    {rst_a, rst_b, rst_c, rst_d} = 4'b0000;
    {raw_a, raw_b, raw_c, raw_d} = '0;
    {sel_a, sel_b, sel_c, sel_d} = '0;
    {clr_a, clr_b, clr_c, clr_d} = '0;
    {en_a, en_b, en_c, en_d}     = {4{2'b11}};
    tick(3);
    check("a_rst_pulse", pulse_a, 0);
    check("a_rst_count", cnt_a, 0);
    check("a_rst_overrun", ovr_a, 0);
    check("b_rst_level", lvl_b, 0);
    check("c_rst_count", cnt_c, 0);
    check("d_rst_level", lvl_d, 0);
    {rst_a, rst_b, rst_c, rst_d} = 4'b1111;
    tick(2);

    // Rising edge latency, no event on release
    q_a.push_back('{0, 1});
    c0 = cyc;
    raw_a[0] = 1'b1;
    tick(8);
    check("a_latency", a_pcyc - c0, 4);
    check("a_level", lvl_a, 1);
    raw_a[0] = 1'b0;
    tick(8);
    check("a_count_after_release", cnt_a, 1);

    // Falling-edge select on channel 1
    sel_a[1] = 1'b1;
    raw_a[1] = 1'b1;
    tick(8);
    check("a_no_event_on_rise_sel1", cnt_a, 1);
    q_a.push_back('{1, 2});
    raw_a[1] = 1'b0;
    tick(8);
    check("a_count_falling", cnt_a, 2);

    // Disabled channel ignored
    en_a[1] = 1'b0;
    raw_a[1] = 1'b1;
    tick(6);
    raw_a[1] = 1'b0;
    tick(8);
    check("a_disabled_count", cnt_a, 2);

    // Debounce: short glitch rejected, long press accepted
    raw_b[1] = 1'b1;
    tick(7);
    raw_b[1] = 1'b0;
    tick(20);
    check("b_glitch_level", lvl_b, 0);
    check("b_glitch_count", cnt_b, 0);
    q_b.push_back('{1, 1});
    c0 = cyc;
    raw_b[1] = 1'b1;
    tick(11);
    check("b_level_early", lvl_b, 0);
    tick(1);
    check("b_level_rise", lvl_b, 2);
    tick(6);
    check("b_latency", b_pcyc - c0, 14);

    // Simultaneous rise, holdoff 3
    q_c.push_back('{0, 1});
    q_c.push_back('{1, 2});
    c0 = cyc;
    raw_c = 2'b11;
    tick(14);
    check("c_first_pulse", c_pcyc[0] - c0, 4);
    check("c_spacing", c_pcyc[1] - c_pcyc[0], 4);
    check("c_count", cnt_c, 2);
    check("c_overrun", ovr_c, 0);
    raw_c = 2'b00;
    tick(10);

    // Reset while holding with channel 1 pending
    q_c.push_back('{0, 3});
    raw_c = 2'b11;
    tick(4);
    check("c_pulse_before_rst", pulse_c, 1);
    rst_c = 1'b0;
    raw_c = 2'b00;
    tick(1);
    check("c_rst_pulse", pulse_c, 0);
    check("c_rst_count", cnt_c, 0);
    check("c_rst_ch", ch_c, 0);
    check("c_rst_level", lvl_c, 0);
    tick(1);
    rst_c = 1'b1;
    tick(30);
    check("c_no_stale_event", c_n, 3);
    check("c_count_after_rst", cnt_c, 0);

    // Three presses within holdoff 20
    q_d.push_back('{0, 1});
    q_d.push_back('{0, 2});
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      raw_d[0] = 1'b1;
      tick(2);
      raw_d[0] = 1'b0;
      tick(2);
    end
    tick(40);
    check("d_second_pulse", d_pcyc - c0, 25);
    check("d_overrun", ovr_d, 1);
    check("d_count", cnt_d, 2);
    clr_d = 1'b1;
    tick(1);
    clr_d = 1'b0;
    check("d_clr_overrun", ovr_d, 0);
    check("d_clr_count", cnt_d, 0);

    // Disabling a channel drops its pending request
    q_d.push_back('{0, 1});
    raw_d = 2'b01;
    tick(1);
    raw_d = 2'b11;
    tick(5);
    en_d[1] = 1'b0;
    tick(2);
    en_d[1] = 1'b1;
    tick(40);
    check("d_pending_cleared", cnt_d, 1);
    raw_d = 2'b00;
    tick(5);

    // Saturation of the 2-bit counter
    d_model = 1;
    for (int k = 0; k < 3; k++) begin
      d_model = (d_model == 3) ? 3 : d_model + 1;
      q_d.push_back('{0, d_model});
      raw_d[0] = 1'b1;
      tick(4);
      raw_d[0] = 1'b0;
      tick(26);
    end
    check("d_saturated", cnt_d, 3);

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    check("c_queue_empty", q_c.size(), 0);
    check("d_queue_empty", q_d.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
